// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Each accepted write is sequenced as SETUP (index and data staged, no
// enable) then COMMIT (enable high). The arbiter also keeps a mask of
// registers with a write in flight so decode can stall on RAW hazards.
//
// Handshake: a requester raises req_valid with req_reg/req_data stable and
// holds them until the cycle its req_ready bit is high; that cycle is the
// transfer. req_ready is combinational, one-hot, and only asserted when the
// FSM is in IDLE or COMMIT and rst is low.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int REG_W   = 3,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_W-1:0]  req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [REG_W-1:0]          rf_write_register_num,
    output logic [DATA_W-1:0]         rf_write_register_in,
    output logic                      rf_write_en,
    output logic [(2**REG_W)-1:0]     pending_mask,
    output logic                      busy,
    output logic [ID_W-1:0]           commit_id,
    output logic [1:0]                fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         cap_id;
    logic                    grant_hit;
    logic [ID_W-1:0]         grant_idx;
    int                      scan_idx;
    logic                    accept;
    logic [REG_W-1:0]        sel_reg;
    logic [DATA_W-1:0]       sel_data;
    logic                    sel_zero;
    logic [(2**REG_W)-1:0]   pending_next;

    assign fsm_state = state;

    // Round-robin search starting one past the last winner; produce the one-hot ready.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        req_ready = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_hit && req_valid[scan_idx]) begin
                grant_hit = 1'b1;
                grant_idx = ID_W'(scan_idx);
            end
        end
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept   = grant_hit && !rst && (state == IDLE || state == COMMIT);
    assign sel_reg  = req_reg[int'(grant_idx)*REG_W +: REG_W];
    assign sel_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_zero = (sel_reg == '0);

    // Next-state: writes to r0 retire in the accept cycle and never enter SETUP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (accept && !sel_zero) ? SETUP : IDLE;
            SETUP:   state_next = COMMIT;
            COMMIT:  state_next = (accept && !sel_zero) ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hazard mask: the committing register clears before a new target sets, so a
    // back-to-back write to the same register keeps its bit high without a gap.
    always_comb begin
        pending_next = pending_mask;
        if (state == COMMIT) begin
            pending_next[rf_write_register_num] = 1'b0;
        end
        if (accept && !sel_zero) begin
            pending_next[sel_reg] = 1'b1;
        end
    end

    // State, pointer, captured write and all registered outputs.
    // rf_write_register_num/in are the capture registers for target and data;
    // they only load on a real (non-r0) accept, so they hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            rr_ptr                <= ID_W'(NUM_REQ - 1);
            cap_id                <= '0;
            rf_write_register_num <= '0;
            rf_write_register_in  <= '0;
            rf_write_en           <= 1'b0;
            pending_mask          <= '0;
            busy                  <= 1'b0;
            commit_id             <= '0;
        end else begin
            state        <= state_next;
            pending_mask <= pending_next;
            rf_write_en  <= (state == SETUP);
            busy         <= (state_next != IDLE);
            if (accept) begin
                rr_ptr <= grant_idx;
                if (!sel_zero) begin
                    cap_id                <= grant_idx;
                    rf_write_register_num <= sel_reg;
                    rf_write_register_in  <= sel_data;
                end
            end
            if (state == SETUP) begin
                commit_id <= cap_id;
            end
        end
    end

endmodule
